alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multicycle issue controller that drives the datapath ALU as its initiator. It accepts one decoded MIPS instruction per valid/ready handshake, maps opcode/funct to an ALU operation, and presents latched operands to the ALU. It captures the result and flags, evaluates overflow traps and branch conditions, and hands a registered writeback record downstream with a second valid/ready handshake. It sits between decode and the register-file writeback stage.

## Interface
- No parameters; word width fixed at 32 (cpu_types_pkg `word_t`).
- CLK  in  1  single clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- req_valid  in  1  decoded instruction available.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_opcode  in  6  `opcode_t`.
- req_funct  in  6  `funct_t`; used when req_opcode is RTYPE.
- req_shamt  in  5  shift amount.
- req_rs_data  in  32  rs operand.
- req_rt_data  in  32  rt operand.
- req_imm16  in  16  immediate field.
- req_dest  in  5  destination register index.
- alu_op  out  4  `aluop_t` to ALU.
- alu_port_a  out  32  ALU op1.
- alu_port_b  out  32  ALU op2.
- alu_shamt  out  5  ALU shift amount.
- alu_res  in  32  ALU result.
- alu_flag_z, alu_flag_n, alu_flag_v  in  1 each  ALU zero/negative/signed-add overflow.
- wb_valid  out  1  writeback record valid.
- wb_ready  in  1  consumer accepts record.
- wb_data  out  32  result.
- wb_dest  out  5  destination index.
- wb_we  out  1  register write enable.
- wb_branch_taken  out  1  BEQ/BNE condition true.
- wb_ovf_trap  out  1  signed-arithmetic overflow exception.
- wb_illegal  out  1  unsupported opcode/funct.

## Operation
- FSM `iss_state_t`: IDLE, EXEC, WB.
- IDLE: req_ready=1. On req_valid: latch operands and dest; decode the op into a registered aluop; go to EXEC.
- EXEC: drive ALU from the latched registers. At the clock edge, register alu_res, the flags and the derived outputs. Go to WB.
- WB: wb_valid=1, and all wb_* fields are held stable. On wb_ready, go to IDLE.
- R-type mapping: SLL/SRL use port_a=rt and shamt. ADD/ADDU→ALU_ADD. SUB/SUBU→ALU_SUB. AND/OR/XOR/NOR/SLT/SLTU map directly.
- I-type mapping:
  - ADDI/ADDIU→ALU_ADD, SLTI→ALU_SLT, SLTIU→ALU_SLTU; these use a sign-extended imm.
  - ANDI/ORI/XORI use a zero-extended imm.
  - LUI→ALU_SLL with port_a={16'b0,imm} and shamt=16.
  - BEQ/BNE→ALU_SUB on rs,rt.
- Overflow handling:
  - ADD/ADDI: trap = alu_flag_v.
  - SUB: trap = (a[31]!=b[31]) && (res[31]!=a[31]), computed locally because the ALU reports no subtract overflow.
  - Unsigned variants never trap.
  - On a trap, wb_we=0.
- Branches: taken = alu_flag_z for BEQ, and !alu_flag_z for BNE. wb_we=0.
- Illegal encoding: wb_illegal=1, wb_we=0, alu_op=ALU_ADD on zero operands. A record is still produced.
- dest=0: wb_we forced to 0 while wb_data is still reported.

## Timing
- Reset (nRST low, asynchronous): state=IDLE; all registered outputs 0; alu_op=ALU_SLL (0); req_ready=1.
- Reset asserted mid-operation discards the in-flight instruction; no wb_valid follows.
- Latency: request handshake at edge N → EXEC during cycle N..N+1 → wb_valid high after edge N+1.
- Throughput: at most one instruction per 3 cycles with wb_ready tied high.
- req_ready is combinational from state only. It does not depend on req_valid or wb_ready.
- wb_valid is held with stable data until wb_ready is sampled high. wb_valid falls the cycle after the handshake.
- ALU outputs are held constant throughout EXEC. In IDLE and WB they hold their last values and are don't-care.

## Structure
- Add to cpu_types_pkg: `iss_state_t` enum {IDLE, EXEC, WB}. Reuse the existing `aluop_t`, `opcode_t`, `funct_t`.
- One natural sub-module: `alu_op_decode`. It is purely combinational and maps {opcode, funct} to {aluop, imm_sext, use_imm, is_lui, is_branch, trap_en, illegal}.
- The ALU itself is instantiated outside, in the datapath.

## Test plan
- ADD, rs=0x7FFFFFFF, rt=1, dest=5 → wb_data=0x80000000, wb_ovf_trap=1, wb_we=0; the same operands with ADDU give trap=0 and we=1.
- SUB, rs=0x80000000, rt=1 → wb_data=0x7FFFFFFF, wb_ovf_trap=1.
- LUI, imm=0xABCD → wb_data=0xABCD0000. ORI, rs=0x1, imm=0x8000 → 0x00008001 (zero-extended). SLTI, rs=0, imm=0xFFFF → wb_data=0 (sign-extended -1).
- BEQ with rs=rt=0x1234 → wb_branch_taken=1, wb_we=0. BNE with the same operands → taken=0.
- Backpressure: hold wb_ready=0 for 5 cycles with req_valid high → wb_* stable, req_ready=0. Release → handshake, then IDLE with req_ready=1 the next cycle.
- Assert nRST in EXEC → outputs 0 immediately; after release, no wb_valid appears for the aborted op. Funct 0x3F → wb_illegal=1, wb_we=0.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: ALU op codes, MIPS opcode/funct
// encodings, issue FSM states and the immediate-extension helper.
package alu_issue_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } iss_state_t;

  // LUI is realised as a left shift of the zero-extended immediate by 16
  localparam logic [4:0] LUI_SHAMT = 5'd16;

  function automatic word_t extend_imm(input logic [15:0] imm, input logic sext);
    return sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the decode-side request, ALU drive/return and writeback record
// signals; master is the controller view, slave the surrounding datapath view.
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;

  logic          req_valid;
  logic          req_ready;
  opcode_t       req_opcode;
  funct_t        req_funct;
  logic [4:0]    req_shamt;
  word_t         req_rs_data;
  word_t         req_rt_data;
  logic [15:0]   req_imm16;
  logic [4:0]    req_dest;

  aluop_t        alu_op;
  word_t         alu_port_a;
  word_t         alu_port_b;
  logic [4:0]    alu_shamt;
  word_t         alu_res;
  logic          alu_flag_z;
  logic          alu_flag_n;
  logic          alu_flag_v;

  logic          wb_valid;
  logic          wb_ready;
  word_t         wb_data;
  logic [4:0]    wb_dest;
  logic          wb_we;
  logic          wb_branch_taken;
  logic          wb_ovf_trap;
  logic          wb_illegal;

  modport master (
    input  req_valid, req_opcode, req_funct, req_shamt, req_rs_data,
           req_rt_data, req_imm16, req_dest,
    output req_ready,
    output alu_op, alu_port_a, alu_port_b, alu_shamt,
    input  alu_res, alu_flag_z, alu_flag_n, alu_flag_v,
    output wb_valid, wb_data, wb_dest, wb_we, wb_branch_taken, wb_ovf_trap,
           wb_illegal,
    input  wb_ready
  );

  modport slave (
    output req_valid, req_opcode, req_funct, req_shamt, req_rs_data,
           req_rt_data, req_imm16, req_dest,
    input  req_ready,
    input  alu_op, alu_port_a, alu_port_b, alu_shamt,
    output alu_res, alu_flag_z, alu_flag_n, alu_flag_v,
    input  wb_valid, wb_data, wb_dest, wb_we, wb_branch_taken, wb_ovf_trap,
           wb_illegal,
    output wb_ready
  );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational opcode/funct decoder: selects the ALU operation and the
// operand-routing and exception-qualifying attributes of an instruction.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  opcode_t opcode,
  input  funct_t  funct,
  output aluop_t  aluop,
  output logic    imm_sext,
  output logic    use_imm,
  output logic    is_lui,
  output logic    is_shift,
  output logic    is_branch,
  output logic    is_bne,
  output logic    trap_en,
  output logic    illegal
);

  // Unknown encodings fall back to an ADD so the datapath still produces a record
  always_comb begin
    aluop     = ALU_ADD;
    imm_sext  = 1'b0;
    use_imm   = 1'b0;
    is_lui    = 1'b0;
    is_shift  = 1'b0;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    trap_en   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  begin aluop = ALU_SLL; is_shift = 1'b1; end
          FN_SRL:  begin aluop = ALU_SRL; is_shift = 1'b1; end
          FN_ADD:  begin aluop = ALU_ADD; trap_en  = 1'b1; end
          FN_ADDU: aluop = ALU_ADD;
          FN_SUB:  begin aluop = ALU_SUB; trap_en  = 1'b1; end
          FN_SUBU: aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_XOR:  aluop = ALU_XOR;
          FN_NOR:  aluop = ALU_NOR;
          FN_SLT:  aluop = ALU_SLT;
          FN_SLTU: aluop = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_BEQ:   begin aluop = ALU_SUB; is_branch = 1'b1; end
      OP_BNE:   begin aluop = ALU_SUB; is_branch = 1'b1; is_bne = 1'b1; end
      OP_ADDI:  begin aluop = ALU_ADD;  use_imm = 1'b1; imm_sext = 1'b1; trap_en = 1'b1; end
      OP_ADDIU: begin aluop = ALU_ADD;  use_imm = 1'b1; imm_sext = 1'b1; end
      OP_SLTI:  begin aluop = ALU_SLT;  use_imm = 1'b1; imm_sext = 1'b1; end
      OP_SLTIU: begin aluop = ALU_SLTU; use_imm = 1'b1; imm_sext = 1'b1; end
      OP_ANDI:  begin aluop = ALU_AND;  use_imm = 1'b1; end
      OP_ORI:   begin aluop = ALU_OR;   use_imm = 1'b1; end
      OP_XORI:  begin aluop = ALU_XOR;  use_imm = 1'b1; end
      OP_LUI:   begin aluop = ALU_SLL;  is_lui  = 1'b1; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multicycle issue controller: accepts a decoded instruction, drives the external
// ALU for one cycle, then holds a registered writeback record until it is taken.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  alu_issue_ctrl_if.master bus
);

  iss_state_t state, state_next;
  logic       load_req, capture_res, req_ready, wb_valid;

  aluop_t dec_aluop;
  logic   dec_imm_sext, dec_use_imm, dec_is_lui, dec_is_shift;
  logic   dec_is_branch, dec_is_bne, dec_trap_en, dec_illegal;

  alu_op_decode u_decode (
    .opcode    (bus.req_opcode),
    .funct     (bus.req_funct),
    .aluop     (dec_aluop),
    .imm_sext  (dec_imm_sext),
    .use_imm   (dec_use_imm),
    .is_lui    (dec_is_lui),
    .is_shift  (dec_is_shift),
    .is_branch (dec_is_branch),
    .is_bne    (dec_is_bne),
    .trap_en   (dec_trap_en),
    .illegal   (dec_illegal)
  );

  aluop_t     op_next, op_q;
  word_t      a_next, b_next, a_q, b_q;
  logic [4:0] shamt_next, shamt_q, dest_q;
  logic       trap_en_q, branch_q, bne_q, illegal_q;

  // Route the request fields onto the two ALU ports according to instruction class
  always_comb begin
    op_next    = dec_aluop;
    a_next     = bus.req_rs_data;
    b_next     = bus.req_rt_data;
    shamt_next = '0;
    if (dec_illegal) begin
      op_next = ALU_ADD;
      a_next  = '0;
      b_next  = '0;
    end else if (dec_is_lui) begin
      a_next     = extend_imm(bus.req_imm16, 1'b0);
      b_next     = '0;
      shamt_next = LUI_SHAMT;
    end else if (dec_is_shift) begin
      a_next     = bus.req_rt_data;
      b_next     = '0;
      shamt_next = bus.req_shamt;
    end else if (dec_use_imm) begin
      b_next = extend_imm(bus.req_imm16, dec_imm_sext);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      if (bus.wb_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    wb_valid    = 1'b0;
    load_req    = 1'b0;
    capture_res = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        load_req  = bus.req_valid;
      end
      EXEC:    capture_res = 1'b1;
      WB:      wb_valid    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q      <= ALU_SLL;
      a_q       <= '0;
      b_q       <= '0;
      shamt_q   <= '0;
      dest_q    <= '0;
      trap_en_q <= 1'b0;
      branch_q  <= 1'b0;
      bne_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load_req) begin
      op_q      <= op_next;
      a_q       <= a_next;
      b_q       <= b_next;
      shamt_q   <= shamt_next;
      dest_q    <= bus.req_dest;
      trap_en_q <= dec_trap_en;
      branch_q  <= dec_is_branch;
      bne_q     <= dec_is_bne;
      illegal_q <= dec_illegal;
    end
  end

  // The ALU only flags add overflow, so subtract overflow is derived here from the sign bits
  logic sub_ovf, trap_now, taken_now, we_now;
  assign sub_ovf   = (a_q[31] != b_q[31]) && (bus.alu_res[31] != a_q[31]);
  assign trap_now  = trap_en_q && (((op_q == ALU_ADD) && bus.alu_flag_v) ||
                                   ((op_q == ALU_SUB) && sub_ovf));
  assign taken_now = branch_q && (bne_q ? !bus.alu_flag_z : bus.alu_flag_z);
  assign we_now    = !branch_q && !illegal_q && !trap_now && (dest_q != 5'd0);

  word_t      wb_data_q;
  logic [4:0] wb_dest_q;
  logic       wb_we_q, wb_taken_q, wb_trap_q, wb_illegal_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
      wb_we_q      <= 1'b0;
      wb_taken_q   <= 1'b0;
      wb_trap_q    <= 1'b0;
      wb_illegal_q <= 1'b0;
    end else if (capture_res) begin
      wb_data_q    <= bus.alu_res;
      wb_dest_q    <= dest_q;
      wb_we_q      <= we_now;
      wb_taken_q   <= taken_now;
      wb_trap_q    <= trap_now;
      wb_illegal_q <= illegal_q;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.alu_op          = op_q;
  assign bus.alu_port_a      = a_q;
  assign bus.alu_port_b      = b_q;
  assign bus.alu_shamt       = shamt_q;
  assign bus.wb_valid        = wb_valid;
  assign bus.wb_data         = wb_data_q;
  assign bus.wb_dest         = wb_dest_q;
  assign bus.wb_we           = wb_we_q;
  assign bus.wb_branch_taken = wb_taken_q;
  assign bus.wb_ovf_trap     = wb_trap_q;
  assign bus.wb_illegal      = wb_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: plays the ALU and both handshake partners, and
// compares every writeback record with an instruction-level MIPS model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  int   num_checks = 0;
  int   num_errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  // Behavioural ALU standing in for the datapath
  logic [31:0] alu_res_m;
  always_comb begin
    alu_res_m = '0;
    case (bus.alu_op)
      ALU_SLL:  alu_res_m = bus.alu_port_a << bus.alu_shamt;
      ALU_SRL:  alu_res_m = bus.alu_port_a >> bus.alu_shamt;
      ALU_ADD:  alu_res_m = bus.alu_port_a + bus.alu_port_b;
      ALU_SUB:  alu_res_m = bus.alu_port_a - bus.alu_port_b;
      ALU_AND:  alu_res_m = bus.alu_port_a & bus.alu_port_b;
      ALU_OR:   alu_res_m = bus.alu_port_a | bus.alu_port_b;
      ALU_XOR:  alu_res_m = bus.alu_port_a ^ bus.alu_port_b;
      ALU_NOR:  alu_res_m = ~(bus.alu_port_a | bus.alu_port_b);
      ALU_SLT:  alu_res_m = ($signed(bus.alu_port_a) < $signed(bus.alu_port_b)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_res_m = (bus.alu_port_a < bus.alu_port_b) ? 32'd1 : 32'd0;
      default:  alu_res_m = '0;
    endcase
  end
  assign bus.alu_res    = alu_res_m;
  assign bus.alu_flag_z = (alu_res_m == 32'd0);
  assign bus.alu_flag_n = alu_res_m[31];
  assign bus.alu_flag_v = (bus.alu_op == ALU_ADD) && (bus.alu_port_a[31] == bus.alu_port_b[31]) &&
                          (alu_res_m[31] != bus.alu_port_a[31]);

  // Instruction-level reference: architectural MIPS result with 64-bit overflow detection
  function automatic void ref_model(
    input  logic [5:0]  opc, input logic [5:0] fn, input logic [4:0] sh,
    input  logic [31:0] rs,  input logic [31:0] rt, input logic [15:0] imm,
    input  logic [4:0]  dest,
    output logic [31:0] data, output logic we, output logic taken,
    output logic trap, output logic ill);
    longint      sx;
    logic [31:0] simm, zimm;
    logic        br;
    simm = {{16{imm[15]}}, imm};
    zimm = {16'h0, imm};
    data = '0; we = 1'b0; taken = 1'b0; trap = 1'b0; ill = 1'b0; br = 1'b0;
    case (opc)
      6'h00: case (fn)
        6'h00: data = rt << sh;
        6'h02: data = rt >> sh;
        6'h20: begin
          sx = longint'($signed(rs)) + longint'($signed(rt));
          data = sx[31:0];
          trap = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
        end
        6'h21: data = rs + rt;
        6'h22: begin
          sx = longint'($signed(rs)) - longint'($signed(rt));
          data = sx[31:0];
          trap = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
        end
        6'h23: data = rs - rt;
        6'h24: data = rs & rt;
        6'h25: data = rs | rt;
        6'h26: data = rs ^ rt;
        6'h27: data = ~(rs | rt);
        6'h2A: data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        6'h2B: data = (rs < rt) ? 32'd1 : 32'd0;
        default: ill = 1'b1;
      endcase
      6'h04: begin br = 1'b1; taken = (rs == rt); data = rs - rt; end
      6'h05: begin br = 1'b1; taken = (rs != rt); data = rs - rt; end
      6'h08: begin
        sx = longint'($signed(rs)) + longint'($signed(simm));
        data = sx[31:0];
        trap = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
      end
      6'h09: data = rs + simm;
      6'h0A: data = ($signed(rs) < $signed(simm)) ? 32'd1 : 32'd0;
      6'h0B: data = (rs < simm) ? 32'd1 : 32'd0;
      6'h0C: data = rs & zimm;
      6'h0D: data = rs | zimm;
      6'h0E: data = rs ^ zimm;
      6'h0F: data = {imm, 16'h0};
      default: ill = 1'b1;
    endcase
    we = !ill && !trap && !br && (dest != 5'd0);
  endfunction

  // Drives one request, waits for its record and optionally completes the writeback handshake
  task automatic issue(
    input  logic [5:0]  opc, input logic [5:0] fn, input logic [4:0] sh,
    input  logic [31:0] rs,  input logic [31:0] rt, input logic [15:0] imm,
    input  logic [4:0]  dest, input bit do_release,
    output logic [31:0] data, output logic [4:0] wdest, output logic we,
    output logic taken, output logic trap, output logic ill,
    output int lat, output bit timeout);
    int wait_cnt;
    wait_cnt = 0;
    lat = 0;
    @(negedge clk);
    bus.req_opcode  = opcode_t'(opc);
    bus.req_funct   = funct_t'(fn);
    bus.req_shamt   = sh;
    bus.req_rs_data = rs;
    bus.req_rt_data = rt;
    bus.req_imm16   = imm;
    bus.req_dest    = dest;
    bus.req_valid   = 1'b1;
    while (!bus.req_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.wb_valid && lat < 10);
    timeout = !bus.wb_valid || (wait_cnt >= 20);
    data  = bus.wb_data;
    wdest = bus.wb_dest;
    we    = bus.wb_we;
    taken = bus.wb_branch_taken;
    trap  = bus.wb_ovf_trap;
    ill   = bus.wb_illegal;
    if (do_release) begin
      bus.wb_ready = 1'b1;
      @(posedge clk);
      #1 bus.wb_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    num_checks++; if (bus.req_ready !== 1'b1)  begin num_errors++; $display("[TB] FAIL reset req_ready: got %b expected 1", bus.req_ready); end
    num_checks++; if (bus.wb_valid !== 1'b0)   begin num_errors++; $display("[TB] FAIL reset wb_valid: got %b expected 0", bus.wb_valid); end
    num_checks++; if (bus.alu_op !== ALU_SLL)  begin num_errors++; $display("[TB] FAIL reset alu_op: got %0d expected 0", bus.alu_op); end
    num_checks++; if (bus.wb_data !== 32'h0)   begin num_errors++; $display("[TB] FAIL reset wb_data: got %h expected 0", bus.wb_data); end
    num_checks++; if (bus.alu_port_a !== 32'h0) begin num_errors++; $display("[TB] FAIL reset alu_port_a: got %h expected 0", bus.alu_port_a); end
    num_checks++; if ({bus.wb_we, bus.wb_branch_taken, bus.wb_ovf_trap, bus.wb_illegal} !== 4'b0)
      begin num_errors++; $display("[TB] FAIL reset wb flags: got %b expected 0000", {bus.wb_we, bus.wb_branch_taken, bus.wb_ovf_trap, bus.wb_illegal}); end
    nrst = 1'b1;
    @(negedge clk);
    num_checks++; if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0)
      begin num_errors++; $display("[TB] FAIL post-reset idle: got ready=%b valid=%b expected ready=1 valid=0", bus.req_ready, bus.wb_valid); end
  endtask

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  dest;
    logic [31:0] e_data;
    logic        e_we;
    logic        e_taken;
    logic        e_trap;
    logic        e_ill;
  } dcase_t;

  task automatic test_directed();
    dcase_t      tc [17];
    logic [31:0] d;
    logic [4:0]  wd;
    logic        we, tk, tr, il;
    int          lat;
    bit          to;
    tc[0]  = '{6'h00, 6'h20, 5'd0,  32'h7FFFFFFF, 32'h1,        16'h0,    5'd5,  32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tc[1]  = '{6'h00, 6'h21, 5'd0,  32'h7FFFFFFF, 32'h1,        16'h0,    5'd5,  32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    tc[2]  = '{6'h00, 6'h22, 5'd0,  32'h80000000, 32'h1,        16'h0,    5'd3,  32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tc[3]  = '{6'h0F, 6'h00, 5'd0,  32'h0,        32'h0,        16'hABCD, 5'd4,  32'hABCD0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tc[4]  = '{6'h0D, 6'h00, 5'd0,  32'h1,        32'h0,        16'h8000, 5'd6,  32'h00008001, 1'b1, 1'b0, 1'b0, 1'b0};
    tc[5]  = '{6'h0A, 6'h00, 5'd0,  32'h0,        32'h0,        16'hFFFF, 5'd7,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    tc[6]  = '{6'h04, 6'h00, 5'd0,  32'h1234,     32'h1234,     16'h0,    5'd8,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    tc[7]  = '{6'h05, 6'h00, 5'd0,  32'h1234,     32'h1234,     16'h0,    5'd8,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    tc[8]  = '{6'h00, 6'h3F, 5'd0,  32'hDEAD,     32'hBEEF,     16'h0,    5'd9,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
    tc[9]  = '{6'h00, 6'h21, 5'd0,  32'h2,        32'h3,        16'h0,    5'd0,  32'h5,        1'b0, 1'b0, 1'b0, 1'b0};
    tc[10] = '{6'h00, 6'h00, 5'd4,  32'hFFFF0000, 32'h1,        16'h0,    5'd2,  32'h10,       1'b1, 1'b0, 1'b0, 1'b0};
    tc[11] = '{6'h00, 6'h02, 5'd31, 32'h0,        32'h80000000, 16'h0,    5'd10, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0};
    tc[12] = '{6'h0B, 6'h00, 5'd0,  32'h5,        32'h0,        16'hFFFF, 5'd11, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0};
    tc[13] = '{6'h3F, 6'h00, 5'd0,  32'h1,        32'h1,        16'h0,    5'd12, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
    tc[14] = '{6'h00, 6'h23, 5'd0,  32'h80000000, 32'h1,        16'h0,    5'd13, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tc[15] = '{6'h08, 6'h00, 5'd0,  32'h7FFFFFFF, 32'h0,        16'h0001, 5'd14, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tc[16] = '{6'h09, 6'h00, 5'd0,  32'h10,       32'h0,        16'hFFFF, 5'd15, 32'hF,        1'b1, 1'b0, 1'b0, 1'b0};
    foreach (tc[i]) begin
      issue(tc[i].opc, tc[i].fn, tc[i].sh, tc[i].rs, tc[i].rt, tc[i].imm, tc[i].dest, 1'b1,
            d, wd, we, tk, tr, il, lat, to);
      num_checks++; if (to) begin num_errors++; $display("[TB] FAIL directed[%0d] timeout: got no wb_valid expected wb_valid", i); end
      num_checks++; if (d !== tc[i].e_data) begin num_errors++; $display("[TB] FAIL directed[%0d] wb_data: got %h expected %h", i, d, tc[i].e_data); end
      num_checks++; if (wd !== tc[i].dest) begin num_errors++; $display("[TB] FAIL directed[%0d] wb_dest: got %0d expected %0d", i, wd, tc[i].dest); end
      num_checks++; if (we !== tc[i].e_we) begin num_errors++; $display("[TB] FAIL directed[%0d] wb_we: got %b expected %b", i, we, tc[i].e_we); end
      num_checks++; if (tk !== tc[i].e_taken) begin num_errors++; $display("[TB] FAIL directed[%0d] taken: got %b expected %b", i, tk, tc[i].e_taken); end
      num_checks++; if (tr !== tc[i].e_trap) begin num_errors++; $display("[TB] FAIL directed[%0d] ovf_trap: got %b expected %b", i, tr, tc[i].e_trap); end
      num_checks++; if (il !== tc[i].e_ill) begin num_errors++; $display("[TB] FAIL directed[%0d] illegal: got %b expected %b", i, il, tc[i].e_ill); end
      num_checks++; if (lat != 2) begin num_errors++; $display("[TB] FAIL directed[%0d] latency: got %0d expected 2", i, lat); end
    end
  endtask

  function automatic logic [31:0] pick_word();
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0:       w = 32'h7FFFFFFF;
      1:       w = 32'h80000000;
      2:       w = 32'hFFFFFFFF;
      3:       w = 32'h0;
      default: w = $urandom();
    endcase
    return w;
  endfunction

  task automatic test_random();
    logic [5:0]  opcs [11];
    logic [5:0]  fns  [12];
    logic [5:0]  opc, fn;
    logic [4:0]  sh, dest, wd;
    logic [31:0] rs, rt, d, e_d;
    logic [15:0] imm;
    logic        we, tk, tr, il, e_we, e_tk, e_tr, e_il;
    int          lat;
    bit          to;
    opcs = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    fns  = '{6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    for (int n = 0; n < 60; n++) begin
      opc  = ($urandom_range(0, 2) != 0) ? 6'h00 : opcs[$urandom_range(0, 10)];
      fn   = fns[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) opc = 6'($urandom());
      if ($urandom_range(0, 15) == 0) fn  = 6'($urandom());
      sh   = 5'($urandom());
      rs   = pick_word();
      rt   = ($urandom_range(0, 3) == 0) ? rs : pick_word();
      imm  = 16'($urandom());
      dest = 5'($urandom_range(0, 31));
      ref_model(opc, fn, sh, rs, rt, imm, dest, e_d, e_we, e_tk, e_tr, e_il);
      issue(opc, fn, sh, rs, rt, imm, dest, 1'b1, d, wd, we, tk, tr, il, lat, to);
      num_checks++; if (to) begin num_errors++; $display("[TB] FAIL random[%0d] timeout: got no wb_valid expected wb_valid", n); end
      num_checks++; if (d !== e_d) begin num_errors++; $display("[TB] FAIL random[%0d] wb_data op=%h fn=%h: got %h expected %h", n, opc, fn, d, e_d); end
      num_checks++; if (wd !== dest) begin num_errors++; $display("[TB] FAIL random[%0d] wb_dest: got %0d expected %0d", n, wd, dest); end
      num_checks++; if ({we, tk, tr, il} !== {e_we, e_tk, e_tr, e_il})
        begin num_errors++; $display("[TB] FAIL random[%0d] we/taken/trap/illegal op=%h fn=%h: got %b expected %b", n, opc, fn, {we, tk, tr, il}, {e_we, e_tk, e_tr, e_il}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rs, rt, e_d;
    logic        e_we, e_tk, e_tr, e_il;
    logic        exp_valid, exp_ready;
    rs = $urandom();
    rt = $urandom();
    @(negedge clk);
    bus.req_opcode  = OP_RTYPE;
    bus.req_funct   = FN_ADDU;
    bus.req_shamt   = '0;
    bus.req_imm16   = '0;
    bus.req_dest    = 5'd9;
    bus.req_rs_data = rs;
    bus.req_rt_data = rt;
    bus.req_valid   = 1'b1;
    bus.wb_ready    = 1'b1;
    ref_model(6'h21 - 6'h21, 6'h21, 5'd0, rs, rt, 16'h0, 5'd9, e_d, e_we, e_tk, e_tr, e_il);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp_valid = (i % 3 == 2);
      exp_ready = (i % 3 == 0);
      num_checks++; if (bus.wb_valid !== exp_valid) begin num_errors++; $display("[TB] FAIL b2b cycle %0d wb_valid: got %b expected %b", i, bus.wb_valid, exp_valid); end
      num_checks++; if (bus.req_ready !== exp_ready) begin num_errors++; $display("[TB] FAIL b2b cycle %0d req_ready: got %b expected %b", i, bus.req_ready, exp_ready); end
      if (bus.wb_valid === 1'b1) begin
        num_checks++; if (bus.wb_data !== e_d) begin num_errors++; $display("[TB] FAIL b2b cycle %0d wb_data: got %h expected %h", i, bus.wb_data, e_d); end
        rs = $urandom();
        rt = $urandom();
        bus.req_rs_data = rs;
        bus.req_rt_data = rt;
        ref_model(6'h00, 6'h21, 5'd0, rs, rt, 16'h0, 5'd9, e_d, e_we, e_tk, e_tr, e_il);
      end
    end
    bus.req_valid = 1'b0;
    bus.wb_ready  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [4:0]  wd;
    logic        we, tk, tr, il;
    int          lat;
    bit          to;
    issue(6'h00, 6'h20, 5'd0, 32'd100, 32'd23, 16'h0, 5'd6, 1'b0, d, wd, we, tk, tr, il, lat, to);
    num_checks++; if (to || d !== 32'd123) begin num_errors++; $display("[TB] FAIL backpressure record: got %h (timeout=%b) expected 0000007b", d, to); end
    bus.req_opcode  = OP_RTYPE;
    bus.req_funct   = FN_ADDU;
    bus.req_rs_data = $urandom();
    bus.req_rt_data = $urandom();
    bus.req_dest    = 5'd1;
    bus.req_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      num_checks++; if (bus.wb_valid !== 1'b1 || bus.req_ready !== 1'b0)
        begin num_errors++; $display("[TB] FAIL backpressure cycle %0d valid/ready: got %b/%b expected 1/0", i, bus.wb_valid, bus.req_ready); end
      num_checks++; if (bus.wb_data !== 32'd123 || bus.wb_dest !== 5'd6 || bus.wb_we !== 1'b1)
        begin num_errors++; $display("[TB] FAIL backpressure cycle %0d hold: got data=%h dest=%0d we=%b expected 0000007b/6/1", i, bus.wb_data, bus.wb_dest, bus.wb_we); end
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    num_checks++; if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1)
      begin num_errors++; $display("[TB] FAIL backpressure release: got valid=%b ready=%b expected 0/1", bus.wb_valid, bus.req_ready); end
    bus.req_valid = 1'b0;
    bus.wb_ready  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    @(negedge clk);
    bus.req_opcode  = OP_RTYPE;
    bus.req_funct   = FN_SUB;
    bus.req_rs_data = 32'h55;
    bus.req_rt_data = 32'h11;
    bus.req_dest    = 5'd7;
    bus.req_valid   = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    num_checks++; if (bus.alu_op !== ALU_SUB || bus.alu_port_a !== 32'h55 || bus.alu_port_b !== 32'h11)
      begin num_errors++; $display("[TB] FAIL exec drive: got op=%0d a=%h b=%h expected 3/55/11", bus.alu_op, bus.alu_port_a, bus.alu_port_b); end
    nrst = 1'b0;
    #1;
    num_checks++; if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0)
      begin num_errors++; $display("[TB] FAIL midreset handshake: got ready=%b valid=%b expected 1/0", bus.req_ready, bus.wb_valid); end
    num_checks++; if (bus.wb_data !== 32'h0 || bus.wb_dest !== 5'd0 || bus.wb_we !== 1'b0)
      begin num_errors++; $display("[TB] FAIL midreset wb: got data=%h dest=%0d we=%b expected 0/0/0", bus.wb_data, bus.wb_dest, bus.wb_we); end
    num_checks++; if (bus.alu_op !== ALU_SLL || bus.alu_port_a !== 32'h0)
      begin num_errors++; $display("[TB] FAIL midreset alu: got op=%0d a=%h expected 0/0", bus.alu_op, bus.alu_port_a); end
    @(negedge clk);
    nrst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.wb_valid !== 1'b0) stray++;
    end
    num_checks++; if (stray != 0) begin num_errors++; $display("[TB] FAIL midreset aborted op: got %0d wb_valid cycles expected 0", stray); end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_opcode  = OP_RTYPE;
    bus.req_funct   = FN_SLL;
    bus.req_shamt   = '0;
    bus.req_rs_data = '0;
    bus.req_rt_data = '0;
    bus.req_imm16   = '0;
    bus.req_dest    = '0;
    bus.wb_ready    = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
